// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, midpoint sampling, one-cycle valid/framing-error strobes.
// Strobe appears 2+CLKS_PER_BIT/2+9*CLKS_PER_BIT edges after the start edge; no backpressure, bytes are overwritten.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic       i_RX,
    output logic [7:0] o_DATA_OUT,
    output logic       o_DATA_VALID,
    output logic       o_FRAME_ERROR,
    output logic       o_BUSY
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;

    // Flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state         <= S_IDLE;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            o_DATA_OUT    <= '0;
            o_DATA_VALID  <= 1'b0;
            o_FRAME_ERROR <= 1'b0;
            o_BUSY        <= 1'b0;
        end else begin
            o_DATA_VALID  <= 1'b0;
            o_FRAME_ERROR <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) begin
                        state  <= S_START;
                        o_BUSY <= 1'b1;
                    end
                end
                S_START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state  <= S_IDLE;
                            o_BUSY <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leaving at the stop midpoint lets a back-to-back start bit be caught.
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            o_DATA_OUT   <= shift_reg;
                            o_DATA_VALID <= 1'b1;
                            o_BUSY       <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            o_FRAME_ERROR <= 1'b1;
                            state         <= S_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state  <= S_IDLE;
                        o_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver; the receive-side counterpart of uart_transmitter in INTERFACES/UART.
- Synchronises the asynchronous serial line, detects and qualifies the start bit, and samples each bit at its midpoint.
- Presents each completed byte with a one-cycle valid strobe and flags framing errors.
- Frame format is fixed: idle high, one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.

Parameters:
- CLKS_PER_BIT, 16: i_CLK cycles per serial bit. Even integer, >= 4. Must match the transmitter's bit period.

Ports:
- i_CLK  input  1  system clock, single clock domain.
- i_RESET  input  1  synchronous, active-high reset.
- i_RX  input  1  asynchronous serial line, idle high.
- o_DATA_OUT  output  8  last correctly framed byte; holds until the next good frame.
- o_DATA_VALID  output  1  one-cycle pulse when o_DATA_OUT updates.
- o_FRAME_ERROR  output  1  one-cycle pulse when the stop bit is sampled as 0.
- o_BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - o_DATA_OUT=0x00, o_DATA_VALID=0, o_FRAME_ERROR=0, o_BUSY=0.
  - State=IDLE; bit counter and clock counter = 0; shift register = 0x00.
  - Both synchroniser flops = 1.
  - Reset applies at any time, including mid-frame: the partial frame is discarded and no strobe is issued.
- Synchroniser: 2-flop chain on i_RX. The FSM sees only the second flop (rx_s), so there are 2 cycles of input latency.
- Counters:
  - Clock counter spans 0..CLKS_PER_BIT-1. Bit counter is 3 bits. HALF=CLKS_PER_BIT/2.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE:
    - rx_s=0 -> START, clock counter cleared.
  - START:
    - Count up to HALF-1, then sample rx_s.
    - rx_s=1: false start -> IDLE, no strobe.
    - rx_s=0: -> DATA, clock counter and bit counter cleared.
  - DATA:
    - At clock counter = CLKS_PER_BIT-1, sample rx_s into the shift register (right shift, new bit into bit 7, so LSB arrives first). Increment the bit counter and clear the clock counter.
    - After bit 7 is sampled -> STOP.
  - STOP:
    - At clock counter = CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: o_DATA_OUT <= shift register, o_DATA_VALID=1 for one cycle, -> IDLE.
    - rx_s=0: o_FRAME_ERROR=1 for one cycle, o_DATA_OUT unchanged, -> BREAK.
  - BREAK:
    - Wait for rx_s=1 -> IDLE.
    - No further error pulses while the line stays low.
- Timing:
  - Edge 0 is the first i_CLK rising edge at which i_RX is sampled 0.
  - Start qualification occurs at edge 2+HALF.
  - Data bit k (k=0..7) is sampled at edge 2+HALF+(k+1)*CLKS_PER_BIT.
  - The stop bit is sampled at edge 2+HALF+9*CLKS_PER_BIT. o_DATA_VALID or o_FRAME_ERROR is high for the cycle after that edge.
  - For CLKS_PER_BIT=16, that edge is 154.
- Back-to-back frames: the FSM returns to IDLE at the stop-bit midpoint, so a start bit that follows the stop bit with zero idle time is accepted.
- o_DATA_VALID and o_FRAME_ERROR are never high in the same cycle. Both are registered outputs.
- i_RX transitions between sample points are ignored. Only midpoint samples count; no majority voting.

Test Plan:
- Reset, then send 0xA5 with CLKS_PER_BIT=16 -> o_DATA_VALID pulses once, 154 edges after the start edge. o_DATA_OUT=0xA5. o_FRAME_ERROR stays 0. o_BUSY falls the same cycle.
- Send 0x80 then 0x01 back-to-back with no idle gap -> two o_DATA_VALID pulses exactly 160 cycles apart, with o_DATA_OUT=0x80 then 0x01.
- Drive i_RX low for 5 cycles, then high -> o_BUSY rises then returns to 0 after the START sample. No o_DATA_VALID or o_FRAME_ERROR. A subsequent 0x3C frame is received correctly.
- Receive 0x11, then send 0x3C with stop bit=0 -> one o_FRAME_ERROR pulse. o_DATA_OUT stays 0x11 and o_BUSY stays high (BREAK). Raise the line -> IDLE.
- Hold i_RX low for 30 bit times -> exactly one o_FRAME_ERROR pulse and no o_DATA_VALID. After i_RX rises, a 0xFF frame is received correctly.
- Assert i_RESET during data bit 4 of a frame -> next cycle all outputs are at reset values and the state is IDLE. The remaining bits of the aborted frame produce no o_DATA_VALID. (They may trigger a false-start sequence, but never a strobe.)
- Loopback: uart_transmitter o_TX drives i_RX with a matched bit period, sending bytes 0x00, 0x55, 0xAA, 0xFF -> each byte is reproduced in order with no framing errors.
